// File: rtl/output_arb_pkg.sv
// Shared types and defaults for the output FIFO write-port arbiter.
package output_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    localparam int OUT_NREQ   = 4;
    localparam int OUT_DATA_W = 32;

    // Width of a source index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo NREQ.
module rr_priority_pick
    import output_arb_pkg::*;
#(
    parameter  int NREQ = OUT_NREQ,
    localparam int ID_W = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any
);

    int j;

    // Walk the rotated order from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req[j]) begin
                gnt_idx = ID_W'(j);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter feeding the output CDC FIFO write port.
// Each accepted word is tagged with its source index and held in a single
// output register until the FIFO takes it.
module output_fifo_wr_arbiter
    import output_arb_pkg::*;
#(
    parameter  int NREQ   = OUT_NREQ,
    parameter  int DATA_W = OUT_DATA_W,
    localparam int ID_W   = id_w(NREQ)
) (
    input  logic                   wclk,
    input  logic                   wrst_n,
    input  logic                   en,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic                   winc,
    output logic [DATA_W+ID_W-1:0] wdata,
    input  logic                   wfull,
    output logic                   busy
);

    arb_state_t              state_q, state_d;
    logic [ID_W-1:0]         lock_q, lock_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic                    winc_q, winc_d;
    logic [DATA_W+ID_W-1:0]  wdata_q, wdata_d;

    logic [ID_W-1:0]         pick_idx;
    logic                    pick_any;
    logic [ID_W-1:0]         gnt_idx;
    logic                    granted;
    logic                    out_free;
    logic                    accept;

    rr_priority_pick #(.NREQ(NREQ)) u_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // A locked packet owns the port regardless of en; otherwise the round-robin pick does.
    always_comb begin
        if (state_q == ARB_LOCKED) begin
            granted = 1'b1;
            gnt_idx = lock_q;
        end else begin
            granted = en & pick_any;
            gnt_idx = pick_idx;
        end
    end

    // The output register can take a word if it is empty or being drained this cycle.
    assign out_free = ~winc_q | ~wfull;
    // Nothing is accepted while reset is held, so req_ready stays low during reset.
    assign accept   = wrst_n & granted & req_valid[gnt_idx] & out_free;

    // Ready is one-hot on the granted source, or all zero.
    always_comb begin
        req_ready          = '0;
        req_ready[gnt_idx] = accept;
    end

    // Next-state: lock/unlock, pointer advance, and output register load/drain.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        winc_d  = winc_q;
        wdata_d = wdata_q;
        if (accept) begin
            winc_d  = 1'b1;
            wdata_d = {gnt_idx, req_data[int'(gnt_idx)*DATA_W +: DATA_W]};
            if (req_last[gnt_idx]) begin
                state_d = ARB_IDLE;
                ptr_d   = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            end else begin
                state_d = ARB_LOCKED;
                lock_d  = gnt_idx;
            end
        end else if (!wfull) begin
            winc_d = 1'b0;
        end
    end

    // State and output registers; reset drops any held word and any lock.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state_q <= ARB_IDLE;
            lock_q  <= '0;
            ptr_q   <= '0;
            winc_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
            winc_q  <= winc_d;
            wdata_q <= wdata_d;
        end
    end

    assign winc  = winc_q;
    assign wdata = wdata_q;
    assign busy  = (state_q == ARB_LOCKED) | winc_q;

endmodule

// File: tb/tb_output_fifo_wr_arbiter.sv
// Directed table-driven bench for output_fifo_wr_arbiter (NREQ=4, DATA_W=32).
module tb_output_fifo_wr_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 32;
    localparam int WW     = DATA_W + 2;

    logic                   wclk;
    logic                   wrst_n;
    logic                   en;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ready;
    logic                   winc;
    logic [WW-1:0]          wdata;
    logic                   wfull;
    logic                   busy;

    int n_tests = 0;
    int n_fail  = 0;

    output_fifo_wr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .winc      (winc),
        .wdata     (wdata),
        .wfull     (wfull),
        .busy      (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        wfull;
        logic [15:0] tag;
        logic [3:0]  x_ready;
        logic        x_winc;
        logic [WW-1:0] x_wdata;
        logic        x_busy;
    } vec_t;

    vec_t vecs[$];

    // Expected FIFO word: source i drives {tag, i} as payload.
    function automatic logic [WW-1:0] w(input int id, input logic [15:0] tag);
        return {2'(id), tag, 16'(id)};
    endfunction

    function automatic vec_t mk(input logic rst_n, input logic e, input logic [3:0] v,
                                input logic [3:0] l, input logic f, input int tag,
                                input logic [3:0] xr, input logic xw, input int xid,
                                input int xtag, input logic xb);
        vec_t r;
        r.rst_n   = rst_n;
        r.en      = e;
        r.valid   = v;
        r.last    = l;
        r.wfull   = f;
        r.tag     = 16'(tag);
        r.x_ready = xr;
        r.x_winc  = xw;
        r.x_wdata = w(xid, 16'(xtag));
        r.x_busy  = xb;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one vector, check at the falling edge, then advance past the next rising edge.
    task automatic step(input vec_t v, input string tagname);
        wrst_n    = v.rst_n;
        en        = v.en;
        req_valid = v.valid;
        req_last  = v.last;
        wfull     = v.wfull;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = {v.tag, 16'(i)};
        end
        @(negedge wclk);
        chk({tagname, ".ready"}, 64'(req_ready), 64'(v.x_ready));
        chk({tagname, ".winc"},  64'(winc),      64'(v.x_winc));
        chk({tagname, ".wdata"}, 64'(wdata),     64'(v.x_wdata));
        chk({tagname, ".busy"},  64'(busy),      64'(v.x_busy));
        @(posedge wclk);
        #1;
    endtask

    initial begin
        wrst_n    = 1'b0;
        en        = 1'b1;
        req_valid = 4'hF;
        req_last  = 4'hF;
        req_data  = '0;
        wfull     = 1'b0;
        repeat (2) @(posedge wclk);
        #1;

        // Reset state, with requests present but reset still held.
        step(mk(0, 1, 4'hF, 4'hF, 0, 0,  4'h0, 0, 0, 0, 0), "reset");

        // Single-word packets from all sources: ids rotate 0,1,2,3,0.
        vecs.push_back(mk(1, 1, 4'hF, 4'hF, 0, 1,  4'h1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 4'hF, 4'hF, 0, 2,  4'h2, 1, 0, 1, 1));
        vecs.push_back(mk(1, 1, 4'hF, 4'hF, 0, 3,  4'h4, 1, 1, 2, 1));
        vecs.push_back(mk(1, 1, 4'hF, 4'hF, 0, 4,  4'h8, 1, 2, 3, 1));
        vecs.push_back(mk(1, 1, 4'hF, 4'hF, 0, 5,  4'h1, 1, 3, 4, 1));
        // Three-word packet from src1 while src0/src2 wait, then src2, then src0.
        vecs.push_back(mk(1, 1, 4'h7, 4'h5, 0, 6,  4'h2, 1, 0, 5, 1));
        vecs.push_back(mk(1, 1, 4'h7, 4'h5, 0, 7,  4'h2, 1, 1, 6, 1));
        vecs.push_back(mk(1, 1, 4'h7, 4'h7, 0, 8,  4'h2, 1, 1, 7, 1));
        vecs.push_back(mk(1, 1, 4'h5, 4'h5, 0, 9,  4'h4, 1, 1, 8, 1));
        vecs.push_back(mk(1, 1, 4'h1, 4'h1, 0, 10, 4'h1, 1, 2, 9, 1));
        // src2 locks, then drops valid for 4 cycles while others are valid.
        vecs.push_back(mk(1, 1, 4'h4, 4'h0, 0, 11, 4'h4, 1, 0, 10, 1));
        vecs.push_back(mk(1, 1, 4'hB, 4'hB, 0, 12, 4'h0, 1, 2, 11, 1));
        vecs.push_back(mk(1, 1, 4'hB, 4'hB, 0, 13, 4'h0, 0, 2, 11, 1));
        vecs.push_back(mk(1, 1, 4'hB, 4'hB, 0, 14, 4'h0, 0, 2, 11, 1));
        vecs.push_back(mk(1, 1, 4'hB, 4'hB, 0, 15, 4'h0, 0, 2, 11, 1));
        vecs.push_back(mk(1, 1, 4'hF, 4'h4, 0, 16, 4'h4, 0, 2, 11, 1));
        // Word pending, then FIFO full for 5 cycles, then release.
        vecs.push_back(mk(1, 1, 4'h8, 4'h8, 0, 17, 4'h8, 1, 2, 16, 1));
        vecs.push_back(mk(1, 1, 4'hF, 4'hF, 1, 18, 4'h0, 1, 3, 17, 1));
        vecs.push_back(mk(1, 1, 4'hF, 4'hF, 1, 19, 4'h0, 1, 3, 17, 1));
        vecs.push_back(mk(1, 1, 4'hF, 4'hF, 1, 20, 4'h0, 1, 3, 17, 1));
        vecs.push_back(mk(1, 1, 4'hF, 4'hF, 1, 21, 4'h0, 1, 3, 17, 1));
        vecs.push_back(mk(1, 1, 4'hF, 4'hF, 1, 22, 4'h0, 1, 3, 17, 1));
        vecs.push_back(mk(1, 1, 4'hF, 4'hF, 0, 23, 4'h1, 1, 3, 17, 1));
        vecs.push_back(mk(1, 1, 4'h0, 4'h0, 0, 24, 4'h0, 1, 0, 23, 1));
        vecs.push_back(mk(1, 1, 4'h0, 4'h0, 0, 25, 4'h0, 0, 0, 23, 0));
        // en dropped mid-packet from src3: packet finishes, then nothing granted.
        vecs.push_back(mk(1, 1, 4'h8, 4'h0, 0, 26, 4'h8, 0, 0, 23, 0));
        vecs.push_back(mk(1, 0, 4'h8, 4'h0, 0, 27, 4'h8, 1, 3, 26, 1));
        vecs.push_back(mk(1, 0, 4'h9, 4'h9, 0, 28, 4'h8, 1, 3, 27, 1));
        vecs.push_back(mk(1, 0, 4'h9, 4'h9, 0, 29, 4'h0, 1, 3, 28, 1));
        vecs.push_back(mk(1, 0, 4'h9, 4'h9, 0, 30, 4'h0, 0, 3, 28, 0));
        vecs.push_back(mk(1, 0, 4'h9, 4'h9, 0, 31, 4'h0, 0, 3, 28, 0));

        foreach (vecs[i]) begin
            step(vecs[i], $sformatf("v%0d", i));
        end

        // Reset during a locked packet: lock, ptr and held word are all cleared.
        step(mk(1, 1, 4'h4, 4'h4, 0, 40, 4'h4, 0, 3, 28, 0), "r_single2");
        step(mk(1, 1, 4'h8, 4'h0, 0, 41, 4'h8, 1, 2, 40, 1), "r_lock3");
        step(mk(0, 1, 4'h8, 4'h0, 0, 42, 4'h0, 1, 3, 41, 1), "r_assert");
        step(mk(1, 1, 4'hE, 4'hE, 0, 43, 4'h2, 0, 0, 0, 0),  "r_after");
        step(mk(1, 1, 4'h0, 4'h0, 0, 44, 4'h0, 1, 1, 43, 1), "r_first");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
